// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM states, item
// select codes, prices and coin values.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VEND  = 2'd1,
        FAULT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_APPLE  = 2'd0,
        SEL_BANANA = 2'd1,
        SEL_CARROT = 2'd2,
        SEL_DATE   = 2'd3
    } item_sel_t;

    localparam logic [7:0] PRICE_APPLE  = 8'd75;
    localparam logic [7:0] PRICE_BANANA = 8'd60;
    localparam logic [7:0] PRICE_CARROT = 8'd45;
    localparam logic [7:0] PRICE_DATE   = 8'd90;

    localparam logic [7:0] COIN5_VAL  = 8'd5;
    localparam logic [7:0] COIN10_VAL = 8'd10;
    localparam logic [7:0] COIN25_VAL = 8'd25;

    localparam logic [7:0] CREDIT_MAX = 8'd99;

    function automatic logic [7:0] price_of(input logic [1:0] sel);
        case (item_sel_t'(sel))
            SEL_APPLE:  return PRICE_APPLE;
            SEL_BANANA: return PRICE_BANANA;
            SEL_CARROT: return PRICE_CARROT;
            default:    return PRICE_DATE;
        endcase
    endfunction

endpackage

// File: rtl/vending_controller_if.sv
// Coin/purchase inputs and dispense/credit outputs of the vending controller.
// CHANGE_RETURN_EN adds the change and change_valid signals.
interface vending_controller_if;
    logic       coin5;
    logic       coin10;
    logic       coin25;
    logic [1:0] sel;
    logic       buy;
    logic [7:0] credit;
    logic       apple;
    logic       banana;
    logic       carrot;
    logic       date;
    logic       error;
    logic       coin_reject;
`ifdef CHANGE_RETURN_EN
    logic [7:0] change;
    logic       change_valid;
`endif

    modport master (
        output coin5, coin10, coin25, sel, buy,
        input  credit, apple, banana, carrot, date, error, coin_reject
`ifdef CHANGE_RETURN_EN
        , input change, change_valid
`endif
    );

    modport slave (
        input  coin5, coin10, coin25, sel, buy,
        output credit, apple, banana, carrot, date, error, coin_reject
`ifdef CHANGE_RETURN_EN
        , output change, change_valid
`endif
    );
endinterface

// File: rtl/vending_controller_hold_timer.sv
// Loadable down-counter shared by VEND and FAULT; done flags the last
// cycle of the hold window so the FSM exits on that edge.
module hold_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic done
);
    logic [3:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           cnt <= 4'd0;
        else if (load)       cnt <= 4'(HOLD_CYCLES);
        else if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end

    assign done = (cnt == 4'd1);
endmodule

// File: rtl/vending_controller.sv
// Vending controller: coin credit accumulation, purchase FSM with timed
// dispense/error hold. Optional macro CHANGE_RETURN_EN returns change on VEND exit.
module vending_controller
    import vend_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    vending_controller_if.slave bus
);
    state_t     state, state_nxt;
    logic [7:0] credit_q, credit_nxt;
    logic [3:0] item_q, item_nxt;
    logic       err_q, err_nxt;
    logic       rej_q, rej_nxt;
    logic       tmr_load, tmr_done;
    logic [1:0] coin_cnt;
    logic [7:0] coin_val;
    logic [7:0] price;
`ifdef CHANGE_RETURN_EN
    logic [7:0] chg_q, chg_nxt;
    logic       chg_vld_q, chg_vld_nxt;
`endif

    hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
        .clk  (clk),
        .reset(reset),
        .load (tmr_load),
        .done (tmr_done)
    );

    assign coin_cnt = 2'(bus.coin5) + 2'(bus.coin10) + 2'(bus.coin25);
    assign coin_val = bus.coin5  ? COIN5_VAL  :
                      bus.coin10 ? COIN10_VAL :
                      bus.coin25 ? COIN25_VAL : 8'd0;
    assign price    = price_of(bus.sel);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            credit_q  <= 8'd0;
            item_q    <= 4'd0;
            err_q     <= 1'b0;
            rej_q     <= 1'b0;
`ifdef CHANGE_RETURN_EN
            chg_q     <= 8'd0;
            chg_vld_q <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            credit_q  <= credit_nxt;
            item_q    <= item_nxt;
            err_q     <= err_nxt;
            rej_q     <= rej_nxt;
`ifdef CHANGE_RETURN_EN
            chg_q     <= chg_nxt;
            chg_vld_q <= chg_vld_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        credit_nxt = credit_q;
        item_nxt   = item_q;
        err_nxt    = err_q;
        rej_nxt    = 1'b0;
        tmr_load   = 1'b0;
`ifdef CHANGE_RETURN_EN
        chg_nxt     = chg_q;
        chg_vld_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (coin_cnt > 2'd1) begin
                    rej_nxt   = 1'b1;
                    err_nxt   = 1'b1;
                    state_nxt = FAULT;
                    tmr_load  = 1'b1;
                end else if (bus.buy) begin
                    // Buy is judged on pre-coin credit; any coin alongside it is returned.
                    rej_nxt  = (coin_cnt != 2'd0);
                    tmr_load = 1'b1;
                    if (credit_q >= price) begin
                        credit_nxt = credit_q - price;
                        item_nxt   = 4'b0001 << bus.sel;
                        state_nxt  = VEND;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = FAULT;
                    end
                end else if (coin_cnt == 2'd1) begin
                    if (credit_q + coin_val <= CREDIT_MAX) credit_nxt = credit_q + coin_val;
                    else                                   rej_nxt    = 1'b1;
                end
            end
            VEND: begin
                rej_nxt = (coin_cnt != 2'd0);
                if (tmr_done) begin
                    item_nxt  = 4'd0;
                    state_nxt = IDLE;
`ifdef CHANGE_RETURN_EN
                    chg_nxt     = credit_q;
                    chg_vld_nxt = 1'b1;
                    credit_nxt  = 8'd0;
`endif
                end
            end
            FAULT: begin
                rej_nxt = (coin_cnt != 2'd0);
                if (tmr_done) begin
                    err_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.credit      = credit_q;
    assign bus.apple       = item_q[0];
    assign bus.banana      = item_q[1];
    assign bus.carrot      = item_q[2];
    assign bus.date        = item_q[3];
    assign bus.error       = err_q;
    assign bus.coin_reject = rej_q;
`ifdef CHANGE_RETURN_EN
    assign bus.change       = chg_q;
    assign bus.change_valid = chg_vld_q;
`endif
endmodule

// File: tb/tb_vending_controller.sv
// Directed and randomized bench for vending_controller against a cycle-level
// behavioural model built from credit arithmetic and a remaining-hold count.
module tb_vending_controller;
    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    vending_controller_if bus();

    vending_controller #(.HOLD_CYCLES(HOLD)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model state
    int price [4] = '{75, 60, 45, 90};
    int m_credit, m_hold, m_item, m_change;
    bit m_err, m_rej, m_cv;

    task automatic model_reset();
        m_credit = 0; m_hold = 0; m_item = -1; m_err = 0; m_rej = 0;
        m_change = 0; m_cv = 0;
    endtask

    task automatic model_edge(input bit c5, c10, c25, input int s, input bit b);
        int n, v;
        n = int'(c5) + int'(c10) + int'(c25);
        v = c5 ? 5 : c10 ? 10 : c25 ? 25 : 0;
        m_cv = 0;
        if (m_hold > 0) begin
            m_rej = (n > 0);
            m_hold--;
            if (m_hold == 0) begin
`ifdef CHANGE_RETURN_EN
                if (m_item >= 0) begin
                    m_change = m_credit; m_cv = 1; m_credit = 0;
                end
`endif
                m_item = -1; m_err = 0;
            end
        end else begin
            m_rej = 0;
            if (n >= 2) begin
                m_rej = 1; m_err = 1; m_hold = HOLD;
            end else if (b) begin
                m_rej = (n > 0);
                m_hold = HOLD;
                if (m_credit >= price[s]) begin
                    m_credit -= price[s]; m_item = s;
                end else m_err = 1;
            end else if (n == 1) begin
                if (m_credit + v <= 99) m_credit += v;
                else m_rej = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("credit", 32'(bus.credit), 32'(m_credit));
        chk("apple", 32'(bus.apple), 32'(m_item == 0));
        chk("banana", 32'(bus.banana), 32'(m_item == 1));
        chk("carrot", 32'(bus.carrot), 32'(m_item == 2));
        chk("date", 32'(bus.date), 32'(m_item == 3));
        chk("error", 32'(bus.error), 32'(m_err));
        chk("coin_reject", 32'(bus.coin_reject), 32'(m_rej));
`ifdef CHANGE_RETURN_EN
        chk("change", 32'(bus.change), 32'(m_change));
        chk("change_valid", 32'(bus.change_valid), 32'(m_cv));
`endif
    endtask

    task automatic step(input bit c5, c10, c25, input int s, input bit b);
        bus.coin5 = c5; bus.coin10 = c10; bus.coin25 = c25;
        bus.sel = 2'(s); bus.buy = b;
        @(posedge clk);
        model_edge(c5, c10, c25, s, b);
        #1;
        bus.coin5 = 0; bus.coin10 = 0; bus.coin25 = 0; bus.buy = 0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, $urandom_range(0, 3), 0);
    endtask

    initial begin
        bus.coin5 = 0; bus.coin10 = 0; bus.coin25 = 0; bus.sel = 0; bus.buy = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        reset = 0;

        // Three quarters then an apple
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("credit_75", 32'(bus.credit), 32'd75);
        step(0, 0, 0, 0, 1);
        chk("credit_after_apple", 32'(bus.credit), 32'd0);
        idle(HOLD + 1);

        // Credit 40, carrot fails
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 2, 1);
        idle(HOLD + 1);
        chk("credit_40_kept", 32'(bus.credit), 32'd40);

        // Credit 90, quarter bounces
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("reject_at_90", 32'(bus.coin_reject), 32'd1);
        idle(1);

        // Two coins at once
        step(1, 1, 0, 0, 0);
        idle(HOLD + 1);

        // Credit 95, banana with simultaneous nickel
        step(1, 0, 0, 0, 0);
        chk("credit_95", 32'(bus.credit), 32'd95);
        step(1, 0, 0, 1, 1);
        chk("credit_35", 32'(bus.credit), 32'd35);
        idle(HOLD + 2);

        // Reset during VEND cycle 2
        while (m_credit < 45) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 2, 1);
        step(0, 0, 0, 1, 0);
        reset = 1;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 0;
        step(1, 0, 0, 0, 0);
        chk("idle_after_reset", 32'(bus.credit), 32'd5);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r, k;
            bit c5, c10, c25, b;
            r = $urandom_range(0, 9);
            c5 = 0; c10 = 0; c25 = 0;
            if (r >= 4 && r <= 7) begin
                k = $urandom_range(0, 2);
                c5 = (k == 0); c10 = (k == 1); c25 = (k == 2);
            end else if (r == 8) begin
                k = $urandom_range(0, 2);
                c5 = (k != 0); c10 = (k != 1); c25 = (k != 2);
            end else if (r == 9) begin
                c5 = 1; c10 = 1; c25 = 1;
            end
            b = ($urandom_range(0, 3) == 0) && (r < 8);
            step(c5, c10, c25, $urandom_range(0, 3), b);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
